vip_radiance_recovery: RTL and testbench

//   Dark-channel dehaze back end. Consumes the per-pixel transmission stream (t*255)

---
 rtl/vip_radiance_recovery_if.sv | 34 +++
 rtl/vip_radiance_recovery.sv | 124 ++++++++++++
 tb/tb_vip_radiance_recovery.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/vip_radiance_recovery_if.sv
// Pixel-stream bundle for the dehaze radiance-recovery stage: hazy pixel, transmission
// and atmospheric light in, recovered pixel with delayed sync out.
interface vip_radiance_recovery_if;
  logic       per_frame_vsync;
  logic       per_frame_href;
  logic       per_frame_clken;
  logic [7:0] per_img_red;
  logic [7:0] per_img_green;
  logic [7:0] per_img_blue;
  logic [7:0] per_transmission;
  logic [7:0] atmospheric_light;
  logic       post_frame_vsync;
  logic       post_frame_href;
  logic       post_frame_clken;
  logic [7:0] post_img_red;
  logic [7:0] post_img_green;
  logic [7:0] post_img_blue;

  modport master (
    output per_frame_vsync, per_frame_href, per_frame_clken,
    output per_img_red, per_img_green, per_img_blue,
    output per_transmission, atmospheric_light,
    input  post_frame_vsync, post_frame_href, post_frame_clken,
    input  post_img_red, post_img_green, post_img_blue
  );

  modport slave (
    input  per_frame_vsync, per_frame_href, per_frame_clken,
    input  per_img_red, per_img_green, per_img_blue,
    input  per_transmission, atmospheric_light,
    output post_frame_vsync, post_frame_href, post_frame_clken,
    output post_img_red, post_img_green, post_img_blue
  );
endinterface

// File: rtl/vip_radiance_recovery.sv
// Scene radiance reconstruction J = A + (I - A) * 255 / max(t, T_MIN), four-stage
// pipeline with per-frame atmospheric light and matched sync delay.
module vip_radiance_recovery #(
  parameter int T_MIN     = 25,
  parameter int A_DEFAULT = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  vip_radiance_recovery_if.slave vif
);

  localparam int         STAGES  = 4;
  localparam logic [7:0] T_MIN8  = 8'(T_MIN);
  localparam logic [7:0] A_DEF8  = 8'(A_DEFAULT);

  // Signed quotient truncated toward zero: divide the magnitude, then restore the sign.
  function automatic logic signed [13:0] div_trunc(input logic signed [17:0] num,
                                                   input logic [7:0] den);
    logic [16:0] mag;
    logic [16:0] quo;
    mag = num[17] ? 17'(-num) : 17'(num);
    quo = mag / {9'd0, den};
    return num[17] ? 14'(-quo) : 14'(quo);
  endfunction

  function automatic logic [7:0] sat_u8(input logic signed [13:0] q,
                                        input logic [7:0] a);
    logic signed [14:0] s;
    s = $signed({q[13], q}) + $signed({7'd0, a});
    if (s < 0)
      return 8'd0;
    else if (s > 15'sd255)
      return 8'hFF;
    else
      return s[7:0];
  endfunction

  logic [7:0]        w_pix [3];
  logic [7:0]        w_teff;

  logic              r_vsync_d1;
  logic [7:0]        r_a_frame;
  logic [STAGES-1:0] r_vsync_sr;
  logic [STAGES-1:0] r_href_sr;
  logic [STAGES-1:0] r_clken_sr;

  logic [7:0]        r_teff_p1;
  logic [7:0]        r_a_p1;
  logic signed [8:0] r_d_p1 [3];

  logic [7:0]         r_teff_p2;
  logic [7:0]         r_a_p2;
  logic signed [17:0] r_p_p2 [3];

  logic [7:0]         r_a_p3;
  logic signed [13:0] r_q_p3 [3];

  logic [7:0]         r_s_p4 [3];

  assign w_pix[0] = vif.per_img_red;
  assign w_pix[1] = vif.per_img_green;
  assign w_pix[2] = vif.per_img_blue;
  assign w_teff   = (vif.per_transmission < T_MIN8) ? T_MIN8 : vif.per_transmission;

  // Edge register resets high so a vsync already asserted at reset release is not an edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vsync_d1 <= 1'b1;
      r_a_frame  <= A_DEF8;
      r_vsync_sr <= '0;
      r_href_sr  <= '0;
      r_clken_sr <= '0;
    end else begin
      r_vsync_d1 <= vif.per_frame_vsync;
      if (!r_vsync_d1 && vif.per_frame_vsync)
        r_a_frame <= vif.atmospheric_light;
      r_vsync_sr <= {r_vsync_sr[STAGES-2:0], vif.per_frame_vsync};
      r_href_sr  <= {r_href_sr[STAGES-2:0],  vif.per_frame_href};
      r_clken_sr <= {r_clken_sr[STAGES-2:0], vif.per_frame_clken};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_teff_p1 <= '0;
      r_a_p1    <= '0;
      r_teff_p2 <= '0;
      r_a_p2    <= '0;
      r_a_p3    <= '0;
      for (int c = 0; c < 3; c++) begin
        r_d_p1[c] <= '0;
        r_p_p2[c] <= '0;
        r_q_p3[c] <= '0;
        r_s_p4[c] <= '0;
      end
    end else begin
      // S1: clamp t, difference against the frame's A, carry A with the pixel
      r_teff_p1 <= w_teff;
      r_a_p1    <= r_a_frame;
      for (int c = 0; c < 3; c++)
        r_d_p1[c] <= $signed({1'b0, w_pix[c]}) - $signed({1'b0, r_a_frame});
      // S2: scale by 255
      r_teff_p2 <= r_teff_p1;
      r_a_p2    <= r_a_p1;
      for (int c = 0; c < 3; c++)
        r_p_p2[c] <= $signed({{9{r_d_p1[c][8]}}, r_d_p1[c]}) * 18'sd255;
      // S3: divide by effective transmission
      r_a_p3 <= r_a_p2;
      for (int c = 0; c < 3; c++)
        r_q_p3[c] <= div_trunc(r_p_p2[c], r_teff_p2);
      // S4: add A back and saturate to 8 bits
      for (int c = 0; c < 3; c++)
        r_s_p4[c] <= sat_u8(r_q_p3[c], r_a_p3);
    end
  end

  assign vif.post_frame_vsync = r_vsync_sr[STAGES-1];
  assign vif.post_frame_href  = r_href_sr[STAGES-1];
  assign vif.post_frame_clken = r_clken_sr[STAGES-1];
  assign vif.post_img_red     = r_clken_sr[STAGES-1] ? r_s_p4[0] : 8'd0;
  assign vif.post_img_green   = r_clken_sr[STAGES-1] ? r_s_p4[1] : 8'd0;
  assign vif.post_img_blue    = r_clken_sr[STAGES-1] ? r_s_p4[2] : 8'd0;

endmodule

// File: tb/tb_vip_radiance_recovery.sv
// Directed bench for vip_radiance_recovery: reference model feeds a scoreboard queue,
// DUT output is popped and compared every cycle.
module tb_vip_radiance_recovery;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  logic [26:0] sb_q [$];
  int          m_a;
  logic        m_vd1;

  vip_radiance_recovery_if vif();

  vip_radiance_recovery #(.T_MIN(25), .A_DEFAULT(255)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .vif   (vif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] ref_ch(input int i, input int a, input int t);
    int te;
    int q;
    int s;
    te = (t < 25) ? 25 : t;
    q  = ((i - a) * 255) / te;
    s  = q + a;
    if (s < 0)   s = 0;
    if (s > 255) s = 255;
    return 8'(s);
  endfunction

  function automatic logic [26:0] ref_out();
    logic [7:0] r, g, b;
    r = 8'd0; g = 8'd0; b = 8'd0;
    if (vif.per_frame_clken) begin
      r = ref_ch(int'(vif.per_img_red),   m_a, int'(vif.per_transmission));
      g = ref_ch(int'(vif.per_img_green), m_a, int'(vif.per_transmission));
      b = ref_ch(int'(vif.per_img_blue),  m_a, int'(vif.per_transmission));
    end
    return {vif.per_frame_vsync, vif.per_frame_href, vif.per_frame_clken, r, g, b};
  endfunction

  task automatic check(input string tag, input logic [26:0] obs, input logic [26:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: push the model's prediction, advance, update model A, compare at negedge.
  task automatic cycle(input string tag);
    logic [26:0] obs;
    logic [26:0] exp;
    if (rst_n)
      sb_q.push_back(ref_out());
    @(posedge clk);
    if (!rst_n) begin
      m_a   = 255;
      m_vd1 = 1'b1;
    end else begin
      if (!m_vd1 && vif.per_frame_vsync)
        m_a = int'(vif.atmospheric_light);
      m_vd1 = vif.per_frame_vsync;
    end
    @(negedge clk);
    obs = {vif.post_frame_vsync, vif.post_frame_href, vif.post_frame_clken,
           vif.post_img_red, vif.post_img_green, vif.post_img_blue};
    if (!rst_n) begin
      sb_q.delete();
      repeat (3) sb_q.push_back(27'd0);
      check({tag, "_rst"}, obs, 27'd0);
    end else if (sb_q.size() >= 4) begin
      exp = sb_q.pop_front();
      check(tag, obs, exp);
    end
  endtask

  task automatic pix(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                     input logic [7:0] t);
    vif.per_frame_clken  = 1'b1;
    vif.per_frame_href   = 1'b1;
    vif.per_img_red      = r;
    vif.per_img_green    = g;
    vif.per_img_blue     = b;
    vif.per_transmission = t;
  endtask

  task automatic idle(input int n, input string tag);
    vif.per_frame_clken = 1'b0;
    vif.per_frame_href  = 1'b0;
    repeat (n) cycle(tag);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    m_a      = 255;
    m_vd1    = 1'b1;
    rst_n    = 1'b0;
    vif.per_frame_vsync   = 1'b0;
    vif.atmospheric_light = 8'd50;
    pix(8'd10, 8'd20, 8'd30, 8'd100);

    // Reset held three clocks with live inputs
    repeat (3) begin
      pix(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      cycle("reset");
    end
    rst_n = 1'b1;

    // Default A before any vsync edge
    pix(8'd0, 8'd128, 8'd255, 8'd128);  cycle("adef");
    pix(8'd40, 8'd200, 8'd90, 8'd0);    cycle("adef");
    idle(5, "adef_idle");

    // A=200 latched at vsync rise; -100*255/128 -> -199, +200 -> 1
    vif.per_frame_vsync   = 1'b1;
    vif.atmospheric_light = 8'd200;
    cycle("alatch_edge");
    vif.atmospheric_light = 8'd3;
    pix(8'd100, 8'd100, 8'd100, 8'd128); cycle("alatch_pix");
    idle(4, "alatch_idle");

    // Saturation with A=100, t at and below T_MIN
    vif.per_frame_vsync = 1'b0;           cycle("sat_lo");
    vif.per_frame_vsync   = 1'b1;
    vif.atmospheric_light = 8'd100;       cycle("sat_edge");
    pix(8'd200, 8'd0, 8'd100, 8'd25);     cycle("sat_t25");
    pix(8'd200, 8'd0, 8'd100, 8'd0);      cycle("sat_t0");
    pix(8'd100, 8'd100, 8'd100, 8'd1);    cycle("i_eq_a");
    idle(4, "sat_idle");

    // Identity at t=255 over 1000 pixels, new random A every 50 pixels
    for (int f = 0; f < 20; f++) begin
      vif.per_frame_vsync = 1'b0;
      idle(1, "id_lo");
      vif.per_frame_vsync   = 1'b1;
      vif.atmospheric_light = 8'($urandom);
      idle(1, "id_edge");
      for (int p = 0; p < 50; p++) begin
        pix(8'($urandom), 8'($urandom), 8'($urandom), 8'd255);
        cycle("identity");
      end
    end
    idle(4, "id_idle");

    // A changes mid-frame without an edge, then takes effect after the next rise
    for (int p = 0; p < 10; p++) begin
      vif.atmospheric_light = 8'($urandom);
      pix(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom_range(0, 255)));
      cycle("amid_hold");
    end
    vif.per_frame_vsync = 1'b0;
    pix(8'd30, 8'd60, 8'd90, 8'd64);      cycle("amid_lo");
    vif.per_frame_vsync   = 1'b1;
    vif.atmospheric_light = 8'd77;
    pix(8'd30, 8'd60, 8'd90, 8'd64);      cycle("amid_edge");
    vif.atmospheric_light = 8'd5;
    pix(8'd30, 8'd60, 8'd90, 8'd64);      cycle("amid_new");
    pix(8'd250, 8'd1, 8'd77, 8'd30);      cycle("amid_new");
    idle(4, "amid_idle");

    // Random sync, gating and data
    for (int k = 0; k < 300; k++) begin
      vif.per_frame_vsync   = 1'($urandom);
      vif.per_frame_href    = 1'($urandom);
      vif.per_frame_clken   = 1'($urandom);
      vif.per_img_red       = 8'($urandom);
      vif.per_img_green     = 8'($urandom);
      vif.per_img_blue      = 8'($urandom);
      vif.per_transmission  = 8'($urandom_range(0, 60));
      vif.atmospheric_light = 8'($urandom);
      cycle("random");
    end

    // Mid-frame reset with vsync held high through release: A returns to default
    vif.per_frame_vsync = 1'b1;
    pix(8'd9, 8'd99, 8'd199, 8'd40);
    rst_n = 1'b0;
    repeat (2) cycle("midrst");
    rst_n = 1'b1;
    vif.atmospheric_light = 8'd10;
    for (int p = 0; p < 6; p++) begin
      pix(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      cycle("post_rst");
    end
    idle(6, "final_idle");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
